// File: rtl/bitmask_enc_seq_pkg.sv
// bitmask_enc_seq_pkg: shared state encoding and default widths
package bitmask_enc_seq_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int IDXW_DEF = 5;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
endpackage

// File: rtl/bitmask_enc_seq_prio_enc.sv
// prio_enc_32_5: lowest-set-bit index of a vector plus an all-zero flag
module prio_enc_32_5
  import bitmask_enc_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_none
);
  assign o_none = ~|i_vec;
  // scan high to low so the lowest set bit is the last one written
  always_comb begin
    o_idx = '0;
    for (int k = WIDTH - 1; k >= 0; k--) if (i_vec[k]) o_idx = IDXW'(k);
  end
endmodule

// File: rtl/bitmask_enc_seq.sv
// bitmask_enc_seq: emits the index of each set mask bit, lowest first, one per handshake
module bitmask_enc_seq
  import bitmask_enc_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             done,
  output logic             busy
);
  state_t           r_state;
  logic [WIDTH-1:0] r_residue;
  logic             r_done;
  logic             w_none;
  logic             w_beat;
  logic             w_acc;
  logic [WIDTH-1:0] w_next;

  prio_enc_32_5 #(.WIDTH(WIDTH), .IDXW(IDXW)) u_prio (
    .i_vec (r_residue),
    .o_idx (out_idx),
    .o_none(w_none)
  );

  assign w_next    = r_residue & (r_residue - WIDTH'(1));
  assign out_valid = r_state == SCAN;
  assign busy      = out_valid;
  assign out_last  = ~w_none & ~|w_next;
  assign done      = r_done;
  assign w_beat    = out_valid & out_ready;
  assign in_ready  = (r_state == IDLE) | (w_beat & out_last);
  assign w_acc     = in_valid & in_ready;

  // FSM: load on accept, strip lowest bit per beat, pulse done when a mask completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_residue <= '0;
      r_done    <= 1'b0;
    end else if (flush) begin
      r_state   <= IDLE;
      r_residue <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (w_acc & ~|in_mask) | (w_beat & out_last);
      if (w_acc) begin
        r_residue <= in_mask;
        r_state   <= |in_mask ? SCAN : IDLE;
      end else if (w_beat) begin
        r_residue <= w_next;
        r_state   <= out_last ? IDLE : SCAN;
      end
    end
  end
endmodule

// File: tb/tb_bitmask_enc_seq.sv
// tb_bitmask_enc_seq: scoreboard bench with directed and random masks
module tb_bitmask_enc_seq;
  typedef struct {
    int idx;
    bit last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        done;
  logic        busy;

  int n_total = 0;
  int n_pass = 0;
  beat_t q[$];
  beat_t pend[$];
  bit zero_acc = 0;
  bit exp_done = 0;

  bitmask_enc_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // every set bit, ascending; last is the one with nothing set above it
  function automatic void expand(input logic [31:0] m);
    for (int i = 0; i < 32; i++)
      if (m[i]) begin
        beat_t b;
        b.idx = i;
        b.last = (m >> (i + 1)) == 0;
        pend.push_back(b);
      end
  endfunction

  // drive one edge's worth of inputs and register the expected response
  task automatic cycle(input bit v, input logic [31:0] m, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid = v;
    in_mask = m;
    out_ready = ordy;
    flush = fl;
    if (v && !fl && (q.size() == 0 || (ordy && q.size() == 1))) begin
      if (m == 0) zero_acc = 1;
      else expand(m);
    end
  endtask

  // monitor: check state after the last edge, then advance the model across the next one
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pend.delete();
      zero_acc = 0;
      exp_done = 0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, q.size() == 0 || (out_ready && q.size() == 1));
      chk("done", done, exp_done);
      if (q.size() != 0) begin
        chk("out_idx", out_idx, q[0].idx);
        chk("out_last", out_last, q[0].last);
      end else begin
        chk("idle_idx", out_idx, 0);
        chk("idle_last", out_last, 0);
      end
      if (flush) begin
        q.delete();
        pend.delete();
        zero_acc = 0;
        exp_done = 0;
      end else begin
        exp_done = zero_acc || (q.size() != 0 && out_ready && q[0].last);
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        while (pend.size() != 0) q.push_back(pend.pop_front());
        zero_acc = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total %0d", n_total);
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    #20;
    rst_n = 1;
    cycle(1, 32'h0000_0001, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 32'h8000_0011, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);
    cycle(1, 32'h0000_000C, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 32'h0, 1, 0);
    repeat (2) cycle(0, 0, 1, 0);
    cycle(1, 32'h0000_0006, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 32'h0000_0100, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 32'hFFFF_FFFF, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 32'h0000_00F0, 1, 1);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 32'hFFFF_FFFF, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", in_ready, 1);
    @(negedge clk);
    #1;
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] m;
      int sel;
      sel = $urandom_range(0, 5);
      m = sel == 0 ? 32'h0 : sel == 1 ? 32'h1 << $urandom_range(0, 31) :
          sel == 2 ? 32'h8000_0000 | (32'h1 << $urandom_range(0, 31)) :
          sel == 3 ? ($urandom & $urandom & $urandom) : $urandom;
      cycle($urandom_range(0, 2) != 0, m, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    repeat (40) cycle(0, 0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
